// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined shifter: op encoding, op field
// positions and the per-stage mux selection.
package shifter_pkg;

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b010;
   localparam logic [2:0] OP_SRA = 3'b011;
   localparam logic [2:0] OP_ROL = 3'b100;
   localparam logic [2:0] OP_ROR = 3'b110;

   localparam int OP_ROT_BIT   = 2;
   localparam int OP_RIGHT_BIT = 1;
   localparam int OP_ARITH_BIT = 0;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_LEFT  = 2'd1,
      MODE_RIGHT = 2'd2,
      MODE_ROT   = 2'd3
   } shift_mode_e;

   // Rotate takes priority over direction; direction of a rotate is
   // resolved inside the stage from the right bit.
   function automatic shift_mode_e stage_mode(input logic shift_en, input logic [2:0] op);
      if (!shift_en)           return MODE_PASS;
      if (op[OP_ROT_BIT])      return MODE_ROT;
      if (op[OP_RIGHT_BIT])    return MODE_RIGHT;
      return MODE_LEFT;
   endfunction

endpackage

// File: rtl/shifter_stage.sv
// One log2 stage of the shifter: conditional shift/rotate by DIST followed
// by a pipeline register with valid/advance handshake.
module shifter_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int TAG_W   = 4,
   parameter int DIST    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_valid,
   output logic               o_adv,
   input  logic [WIDTH-1:0]   i_data,
   input  logic [SHAMT_W-1:0] i_shamt,
   input  logic [2:0]         i_op,
   input  logic [TAG_W-1:0]   i_tag,
   input  logic               i_next_adv,
   output logic               o_valid,
   output logic [WIDTH-1:0]   o_data,
   output logic [SHAMT_W-1:0] o_shamt,
   output logic [2:0]         o_op,
   output logic [TAG_W-1:0]   o_tag
);

   localparam int BIT = $clog2(DIST);

   shift_mode_e        w_mode;
   logic               w_fill;
   logic [WIDTH-1:0]   w_data;

   logic               r_valid;
   logic [WIDTH-1:0]   r_data;
   logic [SHAMT_W-1:0] r_shamt;
   logic [2:0]         r_op;
   logic [TAG_W-1:0]   r_tag;

   assign w_mode = stage_mode(i_shamt[BIT], i_op);
   // Sign comes from this stage's own input MSB, so chained stages compose
   // into an exact arithmetic shift.
   assign w_fill = i_op[OP_ARITH_BIT] & i_data[WIDTH-1];

   always_comb begin
      w_data = i_data;
      case (w_mode)
         MODE_LEFT:  w_data = i_data << DIST;
         MODE_RIGHT: w_data = (i_data >> DIST) | ({WIDTH{w_fill}} & ~({WIDTH{1'b1}} >> DIST));
         MODE_ROT:   w_data = i_op[OP_RIGHT_BIT]
                            ? {i_data[DIST-1:0], i_data[WIDTH-1:DIST]}
                            : {i_data[WIDTH-DIST-1:0], i_data[WIDTH-1:WIDTH-DIST]};
         default:    w_data = i_data;
      endcase
   end

   // An empty stage always accepts, which lets bubbles collapse under a stall.
   assign o_adv = !r_valid || i_next_adv;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_shamt <= '0;
         r_op    <= '0;
         r_tag   <= '0;
      end else if (o_adv) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data  <= w_data;
            r_shamt <= i_shamt;
            r_op    <= i_op;
            r_tag   <= i_tag;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_shamt = r_shamt;
   assign o_op    = r_op;
   assign o_tag   = r_tag;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined shift/rotate unit: one registered stage per shift-amount bit,
// MSB first, with valid/ready on both sides and full backpressure.
module shifter_pipe
   import shifter_pkg::*;
#(
   parameter  int WIDTH   = 32,
   parameter  int TAG_W   = 4,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [SHAMT_W-1:0] in_b,
   input  logic [2:0]         in_op,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_z,
   output logic [TAG_W-1:0]   out_tag
);

   // Index k is the input of stage k; index SHAMT_W is the output side.
   logic               w_valid [0:SHAMT_W];
   logic               w_adv   [0:SHAMT_W];
   logic [WIDTH-1:0]   w_data  [0:SHAMT_W];
   logic [SHAMT_W-1:0] w_shamt [0:SHAMT_W];
   logic [2:0]         w_op    [0:SHAMT_W];
   logic [TAG_W-1:0]   w_tag   [0:SHAMT_W];
   logic               w_unused_tail;

   assign w_valid[0]       = in_valid;
   assign w_data[0]        = in_a;
   assign w_shamt[0]       = in_b;
   assign w_op[0]          = in_op;
   assign w_tag[0]         = in_tag;
   assign w_adv[SHAMT_W]   = out_ready;

   genvar gi;
   generate
      for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
         shifter_stage #(
            .WIDTH   (WIDTH),
            .SHAMT_W (SHAMT_W),
            .TAG_W   (TAG_W),
            .DIST    (1 << (SHAMT_W - 1 - gi))
         ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .i_valid    (w_valid[gi]),
            .o_adv      (w_adv[gi]),
            .i_data     (w_data[gi]),
            .i_shamt    (w_shamt[gi]),
            .i_op       (w_op[gi]),
            .i_tag      (w_tag[gi]),
            .i_next_adv (w_adv[gi+1]),
            .o_valid    (w_valid[gi+1]),
            .o_data     (w_data[gi+1]),
            .o_shamt    (w_shamt[gi+1]),
            .o_op       (w_op[gi+1]),
            .o_tag      (w_tag[gi+1])
         );
      end
   endgenerate

   // Requests seen while rst is high are flushed by the reset itself.
   assign in_ready  = rst || w_adv[0];
   assign out_valid = w_valid[SHAMT_W];
   assign out_z     = w_data[SHAMT_W];
   assign out_tag   = w_tag[SHAMT_W];

   // The last stage's amount/op sideband has no consumer.
   assign w_unused_tail = ^{w_shamt[SHAMT_W], w_op[SHAMT_W]};

endmodule
